usb_crc16_tx_seq: RTL and testbench
===================================

# usb_crc16_tx_seq

Transmit-side DATA-packet sequencer for the USB device core. Accepts a byte stream of packet payload from the endpoint buffer, forwards it to the packetizer/NRZI stage, and drives the `usb_crc16_byte` engine it instantiates. After the last payload byte it appends the complemented CRC16, two bytes long, in USB wire order. It sits between endpoint TX logic and the bit-stuffing serializer.

## Interface
- `MAX_PAYLOAD`, default 1024: payload byte limit; above it, `oversize_o` is set.
- `LEN_W`, default 11: width of the `len_o` counter; must satisfy 2^LEN_W > MAX_PAYLOAD.
- `clk` input, 1: sole clock.
- `rst_n` input, 1: asynchronous, active-low reset.
- `start_i` input, 1: packet start pulse, honoured only in IDLE.
- `zlp_i` input, 1: sampled with `start_i`; zero-length packet, so no payload phase.
- `s_data_i` input, 8: payload byte.
- `s_valid_i` input, 1: payload byte valid.
- `s_last_i` input, 1: marks the final payload byte.
- `s_ready_o` output, 1: payload byte accepted when `s_valid_i & s_ready_o`.
- `m_data_o` output, 8: outgoing byte (payload, then CRC low, then CRC high).
- `m_valid_o` output, 1: outgoing byte valid.
- `m_last_o` output, 1: marks the second CRC byte.
- `m_ready_i` input, 1: downstream accepts the byte when `m_valid_o & m_ready_i`.
- `busy_o` output, 1: high in any state other than IDLE.
- `len_o` output, LEN_W: payload bytes accepted in the current or last packet; saturates at all-ones.
- `oversize_o` output, 1: sticky; set when the byte count exceeds MAX_PAYLOAD; cleared on the next `start_i`.
- `crc_err_o` output, 1: one-cycle self-check failure pulse; only present with `USB_CRC16_SELFCHECK_EN`.

## Operation
- FSM states: IDLE, CLEAR, PAYLOAD, WAIT_CRC, CRC_LO, CRC_HI.
- IDLE: on `start_i`:
  - pulse engine `clear_i`;
  - zero `len_o` and clear `oversize_o`;
  - go to CLEAR.
- CLEAR: one cycle, lets the engine's 0xFFFF initialisation register. Next state is WAIT_CRC if zlp was latched, otherwise PAYLOAD.
- PAYLOAD:
  - `s_ready_o = ~m_valid_o | m_ready_i`, using a single output register.
  - Each accepted byte goes to `m_data_o` and, in the same cycle, to engine `data_i`/`valid_i`.
  - Each accepted byte increments `len_o`.
  - An accepted byte with `s_last_i` moves the FSM to WAIT_CRC.
- WAIT_CRC:
  - `s_ready_o = 0`.
  - The engine has 2-cycle latency (registered in, registered out). The FSM waits until the engine `valid_o` corresponding to the last fed byte, then latches `crc_tx = ~crc_o`. For ZLP it waits 2 cycles after the CLEAR-state pulse.
  - Enters CRC_LO once the output register is free.
- CRC byte encoding (bit k of each byte is wire bit k):
  - CRC_LO emits byte bit k = `crc_tx[15-k]`.
  - CRC_HI emits byte bit k = `crc_tx[7-k]` with `m_last_o = 1`.
- On the handshake of the CRC_HI byte, the FSM returns to IDLE.
- Output stability: `m_data_o`, `m_valid_o` and `m_last_o` are held stable while `m_valid_o & ~m_ready_i`.
- A `start_i` while busy is ignored.
- `s_valid_i` outside PAYLOAD is ignored and not consumed.
- `oversize_o` sets when byte MAX_PAYLOAD+1 is accepted. That byte and any further bytes are still forwarded.
- Reset (asynchronous, any state) values:
  - FSM state IDLE;
  - `m_valid_o`, `m_last_o`, `s_ready_o`, `busy_o`, `oversize_o`, `crc_err_o` = 0;
  - `m_data_o` = 0x00, `len_o` = 0.
- The engine's reset input is driven by `~rst_n`.

## Timing
- Payload throughput is 1 byte per cycle when `m_ready_i` is held high.
- Last payload byte handshake to first CRC byte `m_valid_o` is 3 cycles.
- Start to first `s_ready_o` is 2 cycles.
- ZLP: `start_i` to CRC_LO valid is 4 cycles; emitted bytes are 0x00, 0x00.
- `busy_o` rises the cycle after `start_i`. It falls the cycle after the CRC_HI handshake.

## Configuration
- `USB_CRC16_SELFCHECK_EN` defined:
  - both emitted CRC bytes are also fed into the engine;
  - 2 cycles after the CRC_HI feed, the engine result is compared with `CRC16_RESIDUAL` (0x800D);
  - on mismatch, `crc_err_o` pulses for 1 cycle;
  - the FSM stays in CRC_HI until the check completes.
- `USB_CRC16_SELFCHECK_EN` undefined: `crc_err_o` is tied 0 and no extra engine feeds occur.

## Structure
- Package `usb_crc_pkg` holds:
  - `CRC16_INIT` = 0xFFFF and `CRC16_RESIDUAL` = 0x800D;
  - the state enum `crc_tx_state_e`;
  - function `crc16_wire_byte(crc, hi)`, which implements the bit-reversed byte select.
- One sub-module: `usb_crc16_byte`, instantiated unchanged.

## Test plan
- Payload ASCII "123456789" (0x31..0x39), `m_ready_i` = 1 → output 0x31..0x39, 0xC8, 0xB4 with `m_last_o` on 0xB4; `len_o` = 9.
- ZLP start → output 0x00, 0x00; `len_o` = 0; `busy_o` high for exactly the expected cycles.
- Random `m_ready_i` backpressure at 50%, 64-byte random payload → output equals payload plus CRC from the reference model; data held stable while stalled.
- MAX_PAYLOAD = 8, 10-byte packet → `oversize_o` set on byte 9; all 10 bytes plus CRC emitted; `oversize_o` cleared on next start.
- Reset asserted mid-PAYLOAD, then a fresh "123456789" packet → all outputs at reset values immediately; second packet ends in 0xC8, 0xB4.
- `USB_CRC16_SELFCHECK_EN`, good packet → no `crc_err_o`. Force-corrupt the latched `crc_tx` → exactly one `crc_err_o` pulse.

Source files
------------

// File: rtl/usb_crc_pkg.sv
// Shared definitions for the USB CRC16 transmit path.
//   CRC16_INIT      : engine start value
//   CRC16_RESIDUAL  : engine value after a good packet plus its CRC has been fed
//   crc_tx_state_e  : transmit sequencer states
//   crc16_next      : one-byte CRC16 update (MSB-first register, LSB-first data)
//   crc16_wire_byte : bit-reversed byte select of a CRC for wire order
package usb_crc_pkg;

  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StPayload,
    StWaitCrc,
    StCrcLo,
    StCrcHi
  } crc_tx_state_e;

  // Register bit 15 is the first CRC bit on the wire; data bit 0 goes out first.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
    return c;
  endfunction

  // Low byte carries crc[15:8] reversed, high byte crc[7:0] reversed.
  function automatic logic [7:0] crc16_wire_byte(input logic [15:0] crc, input logic hi);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) begin
      b[k] = hi ? crc[7-k] : crc[15-k];
    end
    return b;
  endfunction

endpackage

// File: rtl/usb_crc16_byte.sv
// Byte-wide USB CRC16 engine, two-cycle latency (input register, CRC register).
//   clk      : clock
//   rst_i    : asynchronous active-high reset
//   clear_i  : reload CRC16_INIT and drop any byte in flight
//   data_i   : byte to fold into the CRC
//   valid_i  : data_i valid
//   crc_o    : running CRC including every byte whose valid_o has been seen
//   valid_o  : crc_o has just absorbed a byte
module usb_crc16_byte
  import usb_crc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
  output logic [15:0] crc_o,
  output logic        valid_o
);

  logic [7:0]  r_data;
  logic        r_vld;
  logic [15:0] r_crc;
  logic        r_valid_o;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      r_data    <= 8'h00;
      r_vld     <= 1'b0;
      r_crc     <= CRC16_INIT;
      r_valid_o <= 1'b0;
    end else if (clear_i) begin
      r_vld     <= 1'b0;
      r_crc     <= CRC16_INIT;
      r_valid_o <= 1'b0;
    end else begin
      r_data    <= data_i;
      r_vld     <= valid_i;
      r_valid_o <= r_vld;
      if (r_vld) begin
        r_crc <= crc16_next(r_crc, r_data);
      end
    end
  end

  assign crc_o   = r_crc;
  assign valid_o = r_valid_o;

endmodule

// File: rtl/usb_crc16_tx_seq.sv
// USB DATA-packet transmit sequencer: forwards payload bytes and appends the
// complemented CRC16 (low byte, then high byte with m_last_o).
// Optional feature macro: USB_CRC16_SELFCHECK_EN (feeds the emitted CRC back
// into the engine and pulses crc_err_o if the residual is wrong).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start_i, zlp_i      : packet start (IDLE only), zero-length packet flag
//   s_data_i/s_valid_i/s_last_i/s_ready_o : payload stream in
//   m_data_o/m_valid_o/m_last_o/m_ready_i : byte stream out
//   busy_o              : not IDLE
//   len_o               : accepted payload bytes, saturating
//   oversize_o          : sticky, more than MAX_PAYLOAD bytes accepted
//   crc_err_o           : self-check failure pulse (0 without the macro)
module usb_crc16_tx_seq
  import usb_crc_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = 1024,
  parameter int unsigned LEN_W       = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             zlp_i,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  input  logic             s_last_i,
  output logic             s_ready_o,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic [LEN_W-1:0] len_o,
  output logic             oversize_o,
  output logic             crc_err_o
);

  localparam logic [LEN_W-1:0] MaxLen = LEN_W'(MAX_PAYLOAD);

  crc_tx_state_e    r_state, w_state_d;
  logic             r_zlp, w_zlp_d;
  logic [7:0]       r_m_data, w_m_data_d;
  logic             r_m_valid, w_m_valid_d;
  logic             r_m_last, w_m_last_d;
  logic [LEN_W-1:0] r_len, w_len_d;
  logic             r_oversize, w_oversize_d;
  logic [15:0]      r_crc_tx, w_crc_tx_d;
  // Cycles spent in the current state, saturating at 2.
  logic [1:0]       r_wait, w_wait_d;
  logic             w_crc_err_d;

  logic             w_eng_clear, w_eng_valid, w_eng_vld_o;
  logic [7:0]       w_eng_data;
  logic [15:0]      w_eng_crc;
  logic             w_out_free, w_s_ready, w_accept, w_crc_rdy;

  assign w_out_free = ~r_m_valid | m_ready_i;
  assign w_s_ready  = (r_state == StPayload) & w_out_free;
  assign w_accept   = w_s_ready & s_valid_i;

  // Second WAIT_CRC cycle carries the last byte's engine result; later cycles
  // (output still stalled) keep a stable CRC since nothing else is fed.
  assign w_crc_rdy  = r_zlp ? (r_wait != 2'd0)
                            : ((r_wait != 2'd0) & (w_eng_vld_o | r_wait[1]));

  always_comb begin
    w_state_d    = r_state;
    w_zlp_d      = r_zlp;
    w_m_data_d   = r_m_data;
    w_m_valid_d  = r_m_valid;
    w_m_last_d   = r_m_last;
    w_len_d      = r_len;
    w_oversize_d = r_oversize;
    w_crc_tx_d   = r_crc_tx;
    w_crc_err_d  = 1'b0;
    w_eng_clear  = 1'b0;
    w_eng_valid  = 1'b0;
    w_eng_data   = s_data_i;

    if (r_m_valid & m_ready_i) begin
      w_m_valid_d = 1'b0;
      w_m_last_d  = 1'b0;
    end

    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_eng_clear  = 1'b1;
          w_len_d      = '0;
          w_oversize_d = 1'b0;
          w_zlp_d      = zlp_i;
          w_state_d    = StClear;
        end
      end
      StClear: begin
        w_state_d = r_zlp ? StWaitCrc : StPayload;
      end
      StPayload: begin
        if (w_accept) begin
          w_m_data_d  = s_data_i;
          w_m_valid_d = 1'b1;
          w_m_last_d  = 1'b0;
          w_eng_valid = 1'b1;
          if (r_len != '1) begin
            w_len_d = r_len + LEN_W'(1);
          end
          if (r_len >= MaxLen) begin
            w_oversize_d = 1'b1;
          end
          if (s_last_i) begin
            w_state_d = StWaitCrc;
          end
        end
      end
      StWaitCrc: begin
        if (w_crc_rdy && w_out_free) begin
          w_crc_tx_d  = ~w_eng_crc;
          w_m_data_d  = crc16_wire_byte(~w_eng_crc, 1'b0);
          w_m_valid_d = 1'b1;
          w_m_last_d  = 1'b0;
          w_state_d   = StCrcLo;
`ifdef USB_CRC16_SELFCHECK_EN
          w_eng_valid = 1'b1;
          w_eng_data  = crc16_wire_byte(~w_eng_crc, 1'b0);
`endif
        end
      end
      StCrcLo: begin
        if (m_ready_i) begin
          w_m_data_d  = crc16_wire_byte(r_crc_tx, 1'b1);
          w_m_valid_d = 1'b1;
          w_m_last_d  = 1'b1;
          w_state_d   = StCrcHi;
`ifdef USB_CRC16_SELFCHECK_EN
          w_eng_valid = 1'b1;
          w_eng_data  = crc16_wire_byte(r_crc_tx, 1'b1);
`endif
        end
      end
      StCrcHi: begin
`ifdef USB_CRC16_SELFCHECK_EN
        // Second cycle here: the engine has absorbed the high CRC byte.
        if (r_wait == 2'd1) begin
          w_crc_err_d = (w_eng_crc != CRC16_RESIDUAL);
        end
        if ((r_wait != 2'd0) && w_out_free) begin
          w_state_d = StIdle;
        end
`else
        if (m_ready_i) begin
          w_state_d = StIdle;
        end
`endif
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    w_wait_d = (w_state_d != r_state) ? 2'd0 : (r_wait[1] ? r_wait : r_wait + 2'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_zlp      <= 1'b0;
      r_m_data   <= 8'h00;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_len      <= '0;
      r_oversize <= 1'b0;
      r_crc_tx   <= 16'h0000;
      r_wait     <= 2'd0;
    end else begin
      r_state    <= w_state_d;
      r_zlp      <= w_zlp_d;
      r_m_data   <= w_m_data_d;
      r_m_valid  <= w_m_valid_d;
      r_m_last   <= w_m_last_d;
      r_len      <= w_len_d;
      r_oversize <= w_oversize_d;
      r_crc_tx   <= w_crc_tx_d;
      r_wait     <= w_wait_d;
    end
  end

`ifdef USB_CRC16_SELFCHECK_EN
  logic r_crc_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc_err <= 1'b0;
    end else begin
      r_crc_err <= w_crc_err_d;
    end
  end
  assign crc_err_o = r_crc_err;
`else
  assign crc_err_o = 1'b0;
  logic w_unused;
  assign w_unused = w_crc_err_d;
`endif

  usb_crc16_byte u_crc (
    .clk     (clk),
    .rst_i   (~rst_n),
    .clear_i (w_eng_clear),
    .data_i  (w_eng_data),
    .valid_i (w_eng_valid),
    .crc_o   (w_eng_crc),
    .valid_o (w_eng_vld_o)
  );

  assign s_ready_o  = w_s_ready;
  assign m_data_o   = r_m_data;
  assign m_valid_o  = r_m_valid;
  assign m_last_o   = r_m_last;
  assign busy_o     = (r_state != StIdle);
  assign len_o      = r_len;
  assign oversize_o = r_oversize;

endmodule

// File: tb/tb_usb_crc16_tx_seq.sv
// Directed bench for usb_crc16_tx_seq (MAX_PAYLOAD = 8, LEN_W = 4).
module tb_usb_crc16_tx_seq;

  localparam int unsigned MaxPayload = 8;
  localparam int unsigned LenW       = 4;

  logic            clk, rst_n, start_i, zlp_i;
  logic [7:0]      s_data_i;
  logic            s_valid_i, s_last_i, s_ready_o;
  logic [7:0]      m_data_o;
  logic            m_valid_o, m_last_o, m_ready_i, busy_o, oversize_o, crc_err_o;
  logic [LenW-1:0] len_o;

  usb_crc16_tx_seq #(
    .MAX_PAYLOAD (MaxPayload),
    .LEN_W       (LenW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .zlp_i      (zlp_i),
    .s_data_i   (s_data_i),
    .s_valid_i  (s_valid_i),
    .s_last_i   (s_last_i),
    .s_ready_o  (s_ready_o),
    .m_data_o   (m_data_o),
    .m_valid_o  (m_valid_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i),
    .busy_o     (busy_o),
    .len_o      (len_o),
    .oversize_o (oversize_o),
    .crc_err_o  (crc_err_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  bit rdy_rand = 1'b0;
  initial begin
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready_i = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Output capture and timing monitor, sampled on the falling edge.
  logic [7:0] cap_data[$];
  logic       cap_last[$];
  int cyc = 0, busy_cnt = 0, err_cnt = 0;
  int t_start = -1, t_rdy = -1, t_mv = -1, t_acc0 = -1, t_last = -1, t_crc = -1;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (busy_o) busy_cnt++;
      if (crc_err_o) err_cnt++;
      if (prev_stall) begin
        check_eq("hold_valid", 32'(m_valid_o), 32'd1);
        check_eq("hold_data", 32'(m_data_o), 32'(prev_data));
        check_eq("hold_last", 32'(m_last_o), 32'(prev_last));
      end
      if (start_i && !busy_o && t_start < 0) t_start = cyc;
      if (s_ready_o && t_start >= 0 && t_rdy < 0) t_rdy = cyc;
      if (m_valid_o && t_start >= 0 && t_mv < 0) t_mv = cyc;
      if (s_valid_i && s_ready_o && t_acc0 < 0) t_acc0 = cyc;
      if (s_valid_i && s_ready_o && s_last_i) t_last = cyc;
      if (m_valid_o && t_last >= 0 && t_crc < 0 && cyc > t_last + 1) t_crc = cyc;
      if (m_valid_o && m_ready_i) begin
        cap_data.push_back(m_data_o);
        cap_last.push_back(m_last_o);
      end
      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
    end
  end

  function automatic logic [15:0] ref_crc(input logic [7:0] pl[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pl[i]) begin
      c = c ^ {8'h00, pl[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic clear_marks();
    t_start = -1; t_rdy = -1; t_mv = -1; t_acc0 = -1; t_last = -1; t_crc = -1;
    busy_cnt = 0;
  endtask

  // Called just after a rising edge.
  task automatic push_byte(input logic [7:0] b, input bit last);
    int n;
    n = 0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    s_last_i  = last;
    @(negedge clk);
    while (!s_ready_o && n < 500) begin
      n++;
      @(negedge clk);
    end
    if (n >= 500) check_eq("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic do_start(input bit zlp);
    start_i = 1'b1;
    zlp_i   = zlp;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    zlp_i   = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int k;
    k = 0;
    while (cap_data.size() < n && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check_eq("out_timeout", 32'(k >= 3000), 32'd0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic cmp_out(input string tag, input logic [7:0] exp[$]);
    check_eq($sformatf("%s_count", tag), 32'(cap_data.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < cap_data.size(); i++) begin
      check_eq($sformatf("%s_b%0d", tag, i), 32'(cap_data[i]), 32'(exp[i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(cap_last[i]), 32'(i == exp.size() - 1));
    end
    cap_data.delete();
    cap_last.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_m_valid"}, 32'(m_valid_o), 32'd0);
    check_eq({tag, "_m_last"}, 32'(m_last_o), 32'd0);
    check_eq({tag, "_s_ready"}, 32'(s_ready_o), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_eq({tag, "_oversize"}, 32'(oversize_o), 32'd0);
    check_eq({tag, "_crc_err"}, 32'(crc_err_o), 32'd0);
    check_eq({tag, "_m_data"}, 32'(m_data_o), 32'h00);
    check_eq({tag, "_len"}, 32'(len_o), 32'd0);
  endtask

  task automatic run_check_pkt(input string tag);
    logic [7:0] pl[$];
    logic [7:0] exp[$];
    pl  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    exp = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
    clear_marks();
    do_start(1'b0);
    foreach (pl[i]) push_byte(pl[i], i == pl.size() - 1);
    wait_out(exp.size());
    cmp_out(tag, exp);
    check_eq({tag, "_len"}, 32'(len_o), 32'd9);
    check_eq({tag, "_oversize"}, 32'(oversize_o), 32'd1);
    check_eq({tag, "_start_to_ready"}, 32'(t_rdy - t_start), 32'd2);
    check_eq({tag, "_throughput"}, 32'(t_last - t_acc0), 32'd8);
    check_eq({tag, "_last_to_crc"}, 32'(t_crc - t_last), 32'd3);
  endtask

  initial begin
    logic [7:0]  pl[$];
    logic [7:0]  exp[$];
    logic [15:0] c;

    rst_n = 1'b0; start_i = 1'b0; zlp_i = 1'b0;
    s_data_i = 8'h00; s_valid_i = 1'b0; s_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // "123456789" with the sink always ready.
    run_check_pkt("ascii");

    // 10-byte packet over an 8-byte limit.
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'(8'hA0 + i));
    do_start(1'b0);
    for (int i = 0; i < 10; i++) begin
      push_byte(pl[i], i == 9);
      check_eq($sformatf("ovs_flag%0d", i), 32'(oversize_o), 32'(i >= 8));
      check_eq($sformatf("ovs_len%0d", i), 32'(len_o), 32'(i + 1));
    end
    c   = ref_crc(pl);
    exp = pl;
    exp.push_back(c[7:0]);
    exp.push_back(c[15:8]);
    wait_out(exp.size());
    cmp_out("ovs", exp);

    // Zero-length packet; a pending payload byte must not be consumed.
    clear_marks();
    s_data_i  = 8'h5A;
    s_valid_i = 1'b1;
    do_start(1'b1);
    wait_out(2);
    s_valid_i = 1'b0;
    exp = '{8'h00, 8'h00};
    cmp_out("zlp", exp);
    check_eq("zlp_len", 32'(len_o), 32'd0);
    check_eq("zlp_oversize_cleared", 32'(oversize_o), 32'd0);
    check_eq("zlp_busy_cycles", 32'(busy_cnt), 32'd5);
    check_eq("zlp_start_to_valid", 32'(t_mv - t_start), 32'd4);
    check_eq("zlp_no_ready", 32'(t_rdy), 32'hFFFF_FFFF);

    // 64 random bytes under 50% backpressure, with an ignored start mid-packet.
    rdy_rand = 1'b1;
    pl.delete();
    for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(0, 255)));
    do_start(1'b0);
    for (int i = 0; i < 64; i++) begin
      if (i == 10) start_i = 1'b1;
      push_byte(pl[i], i == 63);
      start_i = 1'b0;
    end
    c   = ref_crc(pl);
    exp = pl;
    exp.push_back(c[7:0]);
    exp.push_back(c[15:8]);
    wait_out(exp.size());
    cmp_out("rand", exp);
    check_eq("rand_len_sat", 32'(len_o), 32'd15);
    rdy_rand = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a payload, then a clean packet.
    do_start(1'b0);
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    cap_data.delete();
    cap_last.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_check_pkt("after_rst");

`ifdef USB_CRC16_SELFCHECK_EN
    check_eq("selfcheck_good", 32'(err_cnt), 32'd0);
    err_cnt = 0;
    force dut.r_crc_tx = 16'h1234;
    pl = '{8'h01, 8'h02, 8'h03};
    do_start(1'b0);
    foreach (pl[i]) push_byte(pl[i], i == pl.size() - 1);
    wait_out(5);
    release dut.r_crc_tx;
    cap_data.delete();
    cap_last.delete();
    check_eq("selfcheck_bad", 32'(err_cnt), 32'd1);
`else
    check_eq("crc_err_tied", 32'(err_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
